// File: rtl/reservoir_pkg.sv
// Shared definitions for the reservoir plant model.
// Holds the default geometry, rate and threshold constants, the sensor code
// type with its four legal thermometer codes, and the bundled flow command.
package reservoir_pkg;

    localparam int unsigned LEVEL_W_DEF    = 8;
    localparam int unsigned CAP_DEF        = 200;
    localparam int unsigned INIT_LEVEL_DEF = 0;
    localparam int unsigned TH0_DEF        = 40;
    localparam int unsigned TH1_DEF        = 100;
    localparam int unsigned TH2_DEF        = 160;
    localparam int unsigned TICK_DIV_DEF   = 4;
    localparam int unsigned R0_DEF         = 2;
    localparam int unsigned R1_DEF         = 2;
    localparam int unsigned R2_DEF         = 2;
    localparam int unsigned RD_DEF         = 1;
    localparam int unsigned DRAIN_DEF      = 3;
    localparam int unsigned HYST_DEF       = 4;

    typedef logic [2:0] sensor_t;

    localparam sensor_t S_BELOW0 = 3'b000;
    localparam sensor_t S_ABOVE0 = 3'b001;
    localparam sensor_t S_ABOVE1 = 3'b011;
    localparam sensor_t S_ABOVE2 = 3'b111;

    // Valve and demand commands sampled together on an update edge.
    typedef struct packed {
        logic fr2;
        logic fr1;
        logic fr0;
        logic dfr;
        logic drain_en;
    } flow_cmd_t;

endpackage

// File: rtl/reservoir_sensor.sv
// One level sensor: registered compare of level against threshold TH.
// With RESERVOIR_PLANT_HYST_EN defined the sensor sets at level >= TH and
// releases only below TH-HYST, holding its state in between.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   level        : current plant level
//   above        : registered sensor output
module reservoir_sensor
    import reservoir_pkg::*;
#(
    parameter int unsigned LEVEL_W = LEVEL_W_DEF,
    parameter int unsigned TH      = TH0_DEF,
    parameter int unsigned HYST    = HYST_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LEVEL_W-1:0] level,
    output logic               above
);

`ifdef RESERVOIR_PLANT_HYST_EN
    localparam int unsigned HYST_ON = 1;
`else
    localparam int unsigned HYST_ON = 0;
`endif

    // Release band width; zero collapses the hold region to a plain compare.
    localparam int unsigned BAND    = HYST * HYST_ON;
    localparam int unsigned CLR_INT = (TH > BAND) ? (TH - BAND) : 0;

    localparam logic [LEVEL_W-1:0] SET_LVL = LEVEL_W'(TH);
    localparam logic [LEVEL_W-1:0] CLR_LVL = LEVEL_W'(CLR_INT);

    // Set / release / hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            above <= 1'b0;
        end else if (level >= SET_LVL) begin
            above <= 1'b1;
        end else if (level < CLR_LVL) begin
            above <= 1'b0;
        end
    end

endmodule

// File: rtl/reservoir_plant.sv
// Reservoir plant model: integrates valve flow commands minus a user drain
// once every TICK_DIV clocks, saturating at 0 and CAP, and reports the level
// through three thermometer-coded sensors.
// Optional feature macro: RESERVOIR_PLANT_HYST_EN (sensor release hysteresis).
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   fr2, fr1, fr0, dfr        : inflow valve commands
//   drain_en                  : enables the DRAIN outflow
//   s                         : sensor vector, s[0] lowest threshold
//   level                     : current level
//   tick                      : one-cycle pulse with each level update
//   ovf, unf                  : sticky clip flags at CAP / at 0
module reservoir_plant
    import reservoir_pkg::*;
#(
    parameter int unsigned LEVEL_W    = LEVEL_W_DEF,
    parameter int unsigned CAP        = CAP_DEF,
    parameter int unsigned INIT_LEVEL = INIT_LEVEL_DEF,
    parameter int unsigned TH0        = TH0_DEF,
    parameter int unsigned TH1        = TH1_DEF,
    parameter int unsigned TH2        = TH2_DEF,
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
    parameter int unsigned R0         = R0_DEF,
    parameter int unsigned R1         = R1_DEF,
    parameter int unsigned R2         = R2_DEF,
    parameter int unsigned RD         = RD_DEF,
    parameter int unsigned DRAIN      = DRAIN_DEF,
    parameter int unsigned HYST       = HYST_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fr2,
    input  logic               fr1,
    input  logic               fr0,
    input  logic               dfr,
    input  logic               drain_en,
    output sensor_t            s,
    output logic [LEVEL_W-1:0] level,
    output logic               tick,
    output logic               ovf,
    output logic               unf
);

    // Two guard bits keep level + max inflow and 0 - DRAIN from wrapping.
    localparam int unsigned NW    = LEVEL_W + 2;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [NW-1:0]  CAP_S    = NW'(CAP);
    localparam logic [LEVEL_W-1:0]    CAP_L    = LEVEL_W'(CAP);
    localparam logic [LEVEL_W-1:0]    INIT_L   = LEVEL_W'(INIT_LEVEL);

    logic [CNT_W-1:0]      cnt;
    logic                  upd_c;
    flow_cmd_t             cmd_c;
    logic signed [NW-1:0]  lvl_c;
    logic signed [NW-1:0]  add_c;
    logic signed [NW-1:0]  sub_c;
    logic signed [NW-1:0]  nxt_c;
    logic                  clip_hi_c;
    logic                  clip_lo_c;
    logic [LEVEL_W-1:0]    level_d_c;
    logic                  sen0;
    logic                  sen1;
    logic                  sen2;

    assign upd_c = (cnt == CNT_LAST);

    // Net flow for this tick and the clipped next level.
    always_comb begin
        cmd_c     = '{fr2: fr2, fr1: fr1, fr0: fr0, dfr: dfr, drain_en: drain_en};
        lvl_c     = {2'b00, level};
        add_c     = '0;
        sub_c     = '0;
        if (cmd_c.fr0)      add_c = add_c + NW'(R0);
        if (cmd_c.fr1)      add_c = add_c + NW'(R1);
        if (cmd_c.fr2)      add_c = add_c + NW'(R2);
        if (cmd_c.dfr)      add_c = add_c + NW'(RD);
        if (cmd_c.drain_en) sub_c = NW'(DRAIN);
        nxt_c     = lvl_c + add_c - sub_c;
        clip_lo_c = nxt_c[NW-1];
        clip_hi_c = !clip_lo_c && (nxt_c > CAP_S);
        level_d_c = level;
        if (clip_hi_c) begin
            level_d_c = CAP_L;
        end else if (clip_lo_c) begin
            level_d_c = '0;
        end else begin
            level_d_c = nxt_c[LEVEL_W-1:0];
        end
    end

    // Prescaler, integrator and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= INIT_L;
            tick  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            tick <= upd_c;
            if (upd_c) begin
                cnt   <= '0;
                level <= level_d_c;
                ovf   <= ovf | clip_hi_c;
                unf   <= unf | clip_lo_c;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    reservoir_sensor #(.LEVEL_W(LEVEL_W), .TH(TH0), .HYST(HYST)) u_sen0 (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .above   (sen0)
    );

    reservoir_sensor #(.LEVEL_W(LEVEL_W), .TH(TH1), .HYST(HYST)) u_sen1 (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .above   (sen1)
    );

    reservoir_sensor #(.LEVEL_W(LEVEL_W), .TH(TH2), .HYST(HYST)) u_sen2 (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .above   (sen2)
    );

    assign s = {sen2, sen1, sen0};

endmodule

// File: tb/tb_reservoir_plant.sv
// Self-checking bench for reservoir_plant: directed fill / saturate / drain /
// sampling / mid-run reset sequences followed by randomized valve traffic,
// all compared every clock against a behavioural plant model.
module tb_reservoir_plant;
    import reservoir_pkg::*;

    localparam int CAP      = 200;
    localparam int INIT     = 0;
    localparam int TICK_DIV = 4;
    localparam int R0 = 2, R1 = 2, R2 = 2, RD = 1, DRAIN = 3;
    localparam int TH0 = 40, TH1 = 100, TH2 = 160;
`ifdef RESERVOIR_PLANT_HYST_EN
    localparam int HB = 4;
`else
    localparam int HB = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fr2, fr1, fr0, dfr, drain_en;
    sensor_t    s;
    logic [7:0] level;
    logic       tick, ovf, unf;

    always #5 clk = ~clk;

    reservoir_plant dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fr2      (fr2),
        .fr1      (fr1),
        .fr0      (fr0),
        .dfr      (dfr),
        .drain_en (drain_en),
        .s        (s),
        .level    (level),
        .tick     (tick),
        .ovf      (ovf),
        .unf      (unf)
    );

    // Behavioural plant state.
    int m_level, m_cyc, m_tick, m_ovf, m_unf;
    int m_s [3];
    int th [3] = '{TH0, TH1, TH2};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_sval();
        return m_s[0] + 2 * m_s[1] + 4 * m_s[2];
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int nxt;
        if (!reset_n) begin
            m_level = INIT; m_cyc = 0; m_tick = 0; m_ovf = 0; m_unf = 0;
            for (int i = 0; i < 3; i++) m_s[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_level >= th[i]) m_s[i] = 1;
                else if (m_level < th[i] - HB) m_s[i] = 0;
            end
            m_cyc++;
            m_tick = (m_cyc % TICK_DIV == 0) ? 1 : 0;
            if (m_tick == 1) begin
                nxt = m_level + (fr0 ? R0 : 0) + (fr1 ? R1 : 0) + (fr2 ? R2 : 0)
                      + (dfr ? RD : 0) - (drain_en ? DRAIN : 0);
                if (nxt > CAP) begin
                    m_level = CAP; m_ovf = 1;
                end else if (nxt < 0) begin
                    m_level = 0; m_unf = 1;
                end else begin
                    m_level = nxt;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("level", int'(level), m_level);
        check("s",     int'(s),     m_sval());
        check("tick",  int'(tick),  m_tick);
        check("ovf",   int'(ovf),   m_ovf);
        check("unf",   int'(unf),   m_unf);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_flows(input logic a2, input logic a1, input logic a0,
                             input logic ad, input logic dr);
        fr2 = a2; fr1 = a1; fr0 = a0; dfr = ad; drain_en = dr;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_flows(0, 0, 0, 0, 0);
        run(2);
        check("rst_level", int'(level), INIT);
        check("rst_s",     int'(s),     int'(S_BELOW0));
        check("rst_tick",  int'(tick),  0);
        check("rst_flags", int'({ovf, unf}), 0);
        reset_n = 1'b1;
    endtask

    int pin, pdr;

    initial begin
        reset_n = 1'b0;
        set_flows(0, 0, 0, 0, 0);
        m_level = INIT; m_cyc = 0; m_tick = 0; m_ovf = 0; m_unf = 0;
        for (int i = 0; i < 3; i++) m_s[i] = 0;

        // Fill at +3 per tick, then saturate.
        do_reset();
        set_flows(1, 1, 1, 0, 1);
        run(56);
        check("fill_t14_level", int'(level), 42);
        check("fill_t14_s_lag", int'(s), int'(S_BELOW0));
        run(1);
        check("fill_s001", int'(s), int'(S_ABOVE0));
        run(79);
        check("fill_t34_level", int'(level), 102);
        run(1);
        check("fill_s011", int'(s), int'(S_ABOVE1));
        run(79);
        check("fill_t54_level", int'(level), 162);
        run(1);
        check("fill_s111", int'(s), int'(S_ABOVE2));
        run(50);
        check("pre_sat_level", int'(level), 198);
        check("pre_sat_ovf", int'(ovf), 0);
        run(1);
        check("sat_level", int'(level), CAP);
        check("sat_ovf", int'(ovf), 1);
        run(20);
        check("sat_hold", int'(level), CAP);

        // Drain to empty.
        set_flows(0, 0, 0, 0, 1);
        run(67 * 4 + 4);
        check("drain_level", int'(level), 0);
        check("drain_unf", int'(unf), 1);
        check("drain_ovf_sticky", int'(ovf), 1);
        check("drain_s", int'(s), int'(S_BELOW0));

        // Inputs between update edges are ignored; tick period is TICK_DIV.
        do_reset();
        fr2 = 1'b1;
        run(3);
        fr2 = 1'b0;
        run(1);
        check("sample_level", int'(level), 0);
        check("tick_first", int'(tick), 1);
        run(1);
        check("tick_low", int'(tick), 0);
        run(3);
        check("tick_period", int'(tick), 1);

        // Reset on an update edge at level 120 wins over the update.
        do_reset();
        set_flows(1, 1, 1, 0, 1);
        run(160);
        check("mid_level120", int'(level), 120);
        run(3);
        reset_n = 1'b0;
        run(1);
        check("midrst_level", int'(level), INIT);
        check("midrst_flags", int'({ovf, unf}), 0);
        check("midrst_s", int'(s), int'(S_BELOW0));
        reset_n = 1'b1;
        run(4);

`ifdef RESERVOIR_PLANT_HYST_EN
        // Sensor 0 holds through the release band, clears below TH0-HYST.
        do_reset();
        set_flows(0, 0, 0, 1, 0);
        run(164);
        check("hyst_level41", int'(level), 41);
        run(1);
        check("hyst_set", int'(s), int'(S_ABOVE0));
        set_flows(0, 0, 0, 0, 1);
        run(3);
        check("hyst_level38", int'(level), 38);
        run(1);
        check("hyst_hold", int'(s), int'(S_ABOVE0));
        run(4);
        check("hyst_clear", int'(s), int'(S_BELOW0));
`endif

        // Randomized traffic with occasional resets, in biased segments.
        do_reset();
        for (int seg = 0; seg < 24; seg++) begin
            case ($urandom_range(0, 2))
                0:       begin pin = 85; pdr = 20; end
                1:       begin pin = 20; pdr = 85; end
                default: begin pin = 50; pdr = 50; end
            endcase
            for (int c = 0; c < 150; c++) begin
                fr0      = ($urandom_range(0, 99) < pin);
                fr1      = ($urandom_range(0, 99) < pin);
                fr2      = ($urandom_range(0, 99) < pin);
                dfr      = ($urandom_range(0, 99) < pin);
                drain_en = ($urandom_range(0, 99) < pdr);
                reset_n  = ($urandom_range(0, 499) != 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reservoir_plant.md
# reservoir_plant

Behavioural-synthesizable reservoir plant model: the sensor end of the water-level control loop. It integrates the flow-rate commands (fr2, fr1, fr0, dfr) that a reservoir controller drives, subtracts a constant user drain, and presents the resulting level as the thermometer-coded sensor vector s[2:0]. It closes the loop in controller benches and FPGA demos, so a controller can be exercised against a physical plant rather than against scripted sensor values.

## Interface
- LEVEL_W, 8: level register width; CAP must fit.
- CAP, 200: full-tank level; level saturates here.
- INIT_LEVEL, 0: level loaded at reset.
- TH0 / TH1 / TH2, 40 / 100 / 160: sensor thresholds. Ordering is TH0 < TH1 < TH2 < CAP.
- TICK_DIV, 4: clocks per plant update; legal values are 1 or greater.
- R0 / R1 / R2 / RD, 2 / 2 / 2 / 1: inflow per tick for fr0 / fr1 / fr2 / dfr.
- DRAIN, 3: outflow per tick while drain_en=1.
- HYST, 4: sensor release hysteresis. Only used with RESERVOIR_PLANT_HYST_EN. Adjacent thresholds must be more than HYST apart.

Ports:
- clk, in, 1: clock, rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- fr2, fr1, fr0, dfr, in, 1 each: flow valve commands from the controller.
- drain_en, in, 1: user demand; enables the DRAIN outflow.
- s, out, 3: sensor vector. s[0] is the lowest sensor. Legal values are 000, 001, 011, 111.
- level, out, LEVEL_W: current level.
- tick, out, 1: one-cycle pulse marking a level update.
- ovf, out, 1: sticky flag; an inflow was clipped at CAP.
- unf, out, 1: sticky flag; an outflow was clipped at 0.

## Operation
- Prescaler counter `cnt` runs from 0 to TICK_DIV-1 and wraps.
- tick is registered: tick=1 in the cycle after `cnt` equals TICK_DIV-1.
- On a cycle where `cnt` equals TICK_DIV-1, compute `nxt = level + fr0*R0 + fr1*R1 + fr2*R2 + dfr*RD - drain_en*DRAIN`.
  - Arithmetic is signed, LEVEL_W+2 bits; no intermediate wrap is permitted.
  - If nxt > CAP: level <= CAP and ovf <= 1.
  - If nxt < 0: level <= 0 and unf <= 1.
  - Otherwise level <= nxt.
- Flow inputs are sampled only on the update cycle. Changes between updates have no effect.
- Sensors (without hysteresis): s[i] <= (level >= THi), registered from the current level.
- ovf and unf stay set until reset. Both can be set in the same run, but never on the same tick.
- Simultaneous full inflow and drain: the net value is applied. Clipping is judged on the net value only.

## Timing
- Reset, checked at a clock edge with reset_n=0:
  - level=INIT_LEVEL, cnt=0, tick=0, ovf=0, unf=0, s=000.
  - The first clock after reset loads s from INIT_LEVEL.
- First update occurs TICK_DIV clocks after reset is released. tick is high on the following cycle.
- s lags level by exactly one clock. tick and the new level are visible in the same cycle.
- Reset asserted mid-run overrides everything at that edge, including an update due on the same edge.
- Inputs need to be valid only at the update edge. Output latency from flow change to level change is at most TICK_DIV clocks.

## Configuration
- RESERVOIR_PLANT_HYST_EN defined:
  - Each sensor sets when level >= THi.
  - Each sensor clears only when level < THi-HYST; between those points it holds its previous value.
  - Each sensor holds one state bit.
  - Thermometer monotonicity is guaranteed by the threshold spacing rule.
- RESERVOIR_PLANT_HYST_EN undefined: pure compare as in Operation; HYST is ignored.

## Structure
- Package reservoir_pkg holds:
  - default threshold and rate constants;
  - the sensor code typedef `sensor_t` (logic [2:0]);
  - named constants S_BELOW0=000, S_ABOVE0=001, S_ABOVE1=011, S_ABOVE2=111.
- Sub-module reservoir_sensor: one threshold comparator with optional hysteresis, parameterised by TH and HYST, instantiated three times. The level integrator and prescaler stay in the top module.

## Test plan
- Fill: reset (INIT 0), fr0=fr1=fr2=1, dfr=0, drain_en=1 → net +3 per tick.
  - Level 42 at tick 14; s=001 one clock later.
  - s=011 at level 102 (tick 34); s=111 at level 162 (tick 54).
- Saturate: keep filling past CAP → level holds at 200, ovf=1 from that tick, s=111.
- Drain: from 200, all flows 0, drain_en=1 → level falls 3 per tick to 2, then 0 with unf=1. s steps 111→011→001→000 without skipping codes.
- Hysteresis (macro on): level 41 (s=001) drains to 38 → s stays 001. Below 36 → s=000.
- Prescaler and sampling: pulse fr2 between update edges only → level unchanged. tick period is exactly 4 clocks.
- Reset mid-run at level 120 on an update edge → level=0, flags clear, s=000 next clock, and no update is applied.
